// File: rtl/result_to_bcd.sv
// result_to_bcd: converts a 16-bit binary result into five packed BCD digits
// using a serial shift-and-add-3 (double dabble) loop, plus a leading-zero
// blanking mask for display drivers.
// Optional feature macro: SIGNED_RESULT_EN -- treats bin_in as two's
// complement, converts its magnitude and reports the sign on the neg port.
// Latency from an accepted start to the done pulse is 17 clocks.
module result_to_bcd #(
   parameter int BLANK_ZEROS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd_out,
   output logic [4:0]  blank_mask
`ifdef SIGNED_RESULT_EN
   ,
   output logic        neg
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] shift_q, shift_d;     // binary bits still to be shifted in
   logic [19:0] scratch_q, scratch_d; // BCD digits under construction
   logic [4:0]  iter_q, iter_d;       // completed shift iterations
   logic        done_q, done_d;
   logic [19:0] bcd_q, bcd_d;
   logic [4:0]  mask_q, mask_d;

   logic [19:0] adj;        // scratch with +3 applied to every digit >= 5
   logic [4:0]  digit_zero; // per-digit zero flags of the final scratch value
   logic [4:0]  lead_zero;  // digit i and every digit above it are zero
   logic [15:0] capture_val;

`ifdef SIGNED_RESULT_EN
   logic sign_q, sign_d;    // sign captured at start, published at FINISH
   logic neg_q, neg_d;

   // Two's-complement magnitude; 16'h8000 maps onto itself, i.e. 32768.
   assign capture_val = bin_in[15] ? (~bin_in + 16'd1) : bin_in;
`else
   assign capture_val = bin_in;
`endif

   // Per-digit add-3 correction and zero detection.
   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_digit
         assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                 (scratch_q[gi*4 +: 4] + 4'd3) :
                                 scratch_q[gi*4 +: 4];
         assign digit_zero[gi] = (scratch_q[gi*4 +: 4] == 4'd0);
      end
   endgenerate

   // Leading-zero chain from the most significant digit downwards; the units
   // digit is always shown so a zero result still displays "0".
   assign lead_zero[4] = digit_zero[4];
   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_lead
         assign lead_zero[gi] = lead_zero[gi+1] & digit_zero[gi];
      end
   endgenerate
   assign lead_zero[0] = 1'b0;

   // Next-state and datapath: capture in IDLE, 16 shift steps, then publish.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      iter_d    = iter_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      mask_d    = mask_q;
`ifdef SIGNED_RESULT_EN
      sign_d    = sign_q;
      neg_d     = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d   = capture_val;
               scratch_d = 20'd0;
               iter_d    = 5'd0;
`ifdef SIGNED_RESULT_EN
               sign_d    = bin_in[15];
`endif
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_d, shift_d} = {adj, shift_q} << 1;
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd15) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            bcd_d   = scratch_q;
            mask_d  = (BLANK_ZEROS != 0) ? lead_zero : 5'b00000;
            done_d  = 1'b1;
`ifdef SIGNED_RESULT_EN
            neg_d   = sign_q;
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= 16'd0;
         scratch_q <= 20'd0;
         iter_q    <= 5'd0;
         done_q    <= 1'b0;
         bcd_q     <= 20'd0;
         mask_q    <= 5'd0;
`ifdef SIGNED_RESULT_EN
         sign_q    <= 1'b0;
         neg_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         iter_q    <= iter_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         mask_q    <= mask_d;
`ifdef SIGNED_RESULT_EN
         sign_q    <= sign_d;
         neg_q     <= neg_d;
`endif
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign bcd_out    = bcd_q;
   assign blank_mask = mask_q;
`ifdef SIGNED_RESULT_EN
   assign neg        = neg_q;
`endif

endmodule
